serial_paralelo_rx: RTL and testbench



---
 rtl/serial_paralelo_rx.sv | 117 +++++++++++
 tb/tb_serial_paralelo_rx.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_paralelo_rx.sv
// Serial-to-parallel receiver on the clk8f bit clock.
// Finds comma alignment bit by bit and locks after LOCK_COUNT aligned commas.
// Once locked, it deserializes each MSB-first word into paralelo_out.
// valid_out marks words that are data rather than comma.
module serial_paralelo_rx #(
   parameter logic [7:0]  BC_PATTERN = 8'hBC,
   parameter int unsigned LOCK_COUNT = 4
) (
   input  logic       clk8f,
   input  logic       reset,
   input  logic       serial,
   output logic [7:0] paralelo_out,
   output logic       valid_out,
   output logic       active
);

   localparam logic [3:0] LOCK_CNT = 4'(LOCK_COUNT);

   typedef enum logic [1:0] {
      HUNT,
      LOCKING,
      ACTIVE
   } state_t;

   state_t     state;
   state_t     state_n;
   logic [7:0] sr;
   logic [7:0] word_next;
   logic [7:0] paralelo_n;
   logic [2:0] bitcnt;
   logic [2:0] bitcnt_n;
   logic [3:0] bc_cnt;
   logic [3:0] bc_cnt_n;
   logic       valid_n;
   logic       active_n;
   logic       is_comma;
   logic       boundary;

   assign word_next = {sr[6:0], serial};
   assign is_comma  = (word_next == BC_PATTERN);
   assign boundary  = (bitcnt == 3'd7);

   // State, counters, shift register and output registers.
   always_ff @(posedge clk8f) begin
      if (reset) begin
         sr           <= '0;
         bitcnt       <= '0;
         bc_cnt       <= '0;
         state        <= HUNT;
         paralelo_out <= '0;
         valid_out    <= 1'b0;
         active       <= 1'b0;
      end else begin
         sr           <= word_next;
         bitcnt       <= bitcnt_n;
         bc_cnt       <= bc_cnt_n;
         state        <= state_n;
         paralelo_out <= paralelo_n;
         valid_out    <= valid_n;
         active       <= active_n;
      end
   end

   // Alignment search, lock qualification and word capture at boundaries.
   always_comb begin
      state_n    = state;
      bitcnt_n   = bitcnt + 3'd1;
      bc_cnt_n   = bc_cnt;
      paralelo_n = paralelo_out;
      valid_n    = valid_out;
      active_n   = active;
      case (state)
         HUNT: begin
            // Searching on every bit; word position is meaningless here.
            bitcnt_n = '0;
            bc_cnt_n = '0;
            if (is_comma) begin
               bc_cnt_n = 4'd1;
               if (LOCK_CNT == 4'd1) begin
                  state_n  = ACTIVE;
                  active_n = 1'b1;
               end else begin
                  state_n = LOCKING;
               end
            end
         end
         LOCKING: begin
            if (boundary) begin
               if (is_comma) begin
                  bc_cnt_n = bc_cnt + 4'd1;
                  if ((bc_cnt + 4'd1) == LOCK_CNT) begin
                     state_n  = ACTIVE;
                     active_n = 1'b1;
                  end
               end else begin
                  bc_cnt_n = '0;
                  state_n  = HUNT;
               end
            end
         end
         ACTIVE: begin
            if (boundary) begin
               if (is_comma) begin
                  valid_n = 1'b0;
               end else begin
                  paralelo_n = word_next;
                  valid_n    = 1'b1;
               end
            end
         end
         default: begin
            state_n = HUNT;
         end
      endcase
   end

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// Bench for serial_paralelo_rx.
// A bit-history model derives the expected outputs from the received stream.
// Directed literal checks cover the known test points.
module tb_serial_paralelo_rx;

   localparam logic [7:0]  BC = 8'hBC;
   localparam int unsigned LC = 4;

   logic       clk8f = 1'b0;
   logic       reset = 1'b0;
   logic       serial = 1'b0;
   logic [7:0] paralelo_out;
   logic       valid_out;
   logic       active;

   int  n_checks = 0;
   int  n_fail   = 0;
   bit  chk_en   = 1'b0;
   bit  q[$];
   logic [7:0] sent_q[$];
   logic [7:0] rx_q[$];

   serial_paralelo_rx #(
      .BC_PATTERN (BC),
      .LOCK_COUNT (LC)
   ) dut (
      .clk8f        (clk8f),
      .reset        (reset),
      .serial       (serial),
      .paralelo_out (paralelo_out),
      .valid_out    (valid_out),
      .active       (active)
   );

   always #5 clk8f = ~clk8f;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
      end
   endtask

   // 8-bit window ending at bit index i; bits before reset count as zero.
   function automatic logic [7:0] win(input int i);
      logic [7:0] w;
      int idx;
      w = '0;
      for (int k = 0; k < 8; k++) begin
         idx = i - 7 + k;
         w = {w[6:0], (idx >= 0) ? q[idx] : 1'b0};
      end
      return w;
   endfunction

   // Expected outputs from the bit history since the last reset.
   function automatic void model(output logic [7:0] p, output logic v, output logic a);
      int n;
      int i;
      int j;
      int k;
      int lock_at;
      bit fail;
      logic [7:0] w;
      n = q.size();
      i = 0;
      lock_at = -1;
      p = '0;
      v = 1'b0;
      a = 1'b0;
      while (i < n && lock_at < 0) begin
         if (win(i) == BC) begin
            j = i;
            k = 1;
            fail = 1'b0;
            while (k < int'(LC)) begin
               j += 8;
               if (j >= n) return;
               if (win(j) != BC) begin
                  fail = 1'b1;
                  break;
               end
               k++;
            end
            if (fail) i = j + 1;
            else lock_at = j;
         end else begin
            i++;
         end
      end
      if (lock_at < 0) return;
      a = 1'b1;
      for (int jj = lock_at + 8; jj < n; jj += 8) begin
         w = win(jj);
         if (w != BC) begin
            p = w;
            v = 1'b1;
         end else begin
            v = 1'b0;
         end
      end
   endfunction

   // Record the bit history seen by the receiver.
   always @(posedge clk8f) begin
      if (reset) q.delete();
      else q.push_back(serial);
   end

   // Compare the DUT against the model every cycle, away from the active edge.
   always @(negedge clk8f) begin
      logic [7:0] ep;
      logic       ev;
      logic       ea;
      if (chk_en) begin
         model(ep, ev, ea);
         check("cyc_paralelo_out", paralelo_out, ep);
         check("cyc_valid_out", 8'(valid_out), 8'(ev));
         check("cyc_active", 8'(active), 8'(ea));
      end
   end

   task automatic send_bit(input logic b);
      @(negedge clk8f);
      serial = b;
      @(posedge clk8f);
      #1;
   endtask

   // Send the first nb bits of b, MSB first.
   task automatic send_bits(input logic [7:0] b, input int nb);
      for (int i = 0; i < nb; i++) send_bit(b[7 - i]);
   endtask

   task automatic do_reset();
      @(negedge clk8f);
      reset  = 1'b1;
      serial = 1'b0;
      @(posedge clk8f);
      #1;
      reset  = 1'b0;
      chk_en = 1'b1;
   endtask

   initial begin
      logic [7:0] b;
      repeat (2) @(posedge clk8f);
      do_reset();
      check("rst_paralelo", paralelo_out, 8'h00);
      check("rst_valid", 8'(valid_out), 8'h00);
      check("rst_active", 8'(active), 8'h00);

      // Four aligned commas: lock on the last bit of the fourth.
      repeat (3) send_bits(BC, 8);
      send_bits(BC, 7);
      check("t1_active_pre", 8'(active), 8'h00);
      send_bit(1'b0);
      check("t1_active", 8'(active), 8'h01);
      check("t1_valid", 8'(valid_out), 8'h00);
      check("t1_paralelo", paralelo_out, 8'h00);

      // Data words with an idle slot.
      send_bits(8'hA5, 7);
      check("t2_a5_pre_par", paralelo_out, 8'h00);
      check("t2_a5_pre_valid", 8'(valid_out), 8'h00);
      send_bit(1'b1);
      check("t2_a5_par", paralelo_out, 8'hA5);
      check("t2_a5_valid", 8'(valid_out), 8'h01);
      send_bits(8'h3C, 8);
      check("t2_3c_par", paralelo_out, 8'h3C);
      check("t2_3c_valid", 8'(valid_out), 8'h01);
      send_bits(BC, 8);
      check("t2_bc_par", paralelo_out, 8'h3C);
      check("t2_bc_valid", 8'(valid_out), 8'h00);
      send_bits(8'hFF, 7);
      check("t2_ff_pre_par", paralelo_out, 8'h3C);
      send_bit(1'b1);
      check("t2_ff_par", paralelo_out, 8'hFF);
      check("t2_ff_valid", 8'(valid_out), 8'h01);

      // Stream offset by three leading bits.
      do_reset();
      send_bits(8'b1010_0000, 3);
      repeat (4) send_bits(BC, 8);
      check("t3_active", 8'(active), 8'h01);
      send_bits(8'h81, 8);
      check("t3_81_par", paralelo_out, 8'h81);
      check("t3_81_valid", 8'(valid_out), 8'h01);

      // Lock attempt broken by a data word, then a clean four-comma run.
      do_reset();
      repeat (2) send_bits(BC, 8);
      send_bits(8'h55, 8);
      check("t4_after55_active", 8'(active), 8'h00);
      repeat (3) send_bits(BC, 8);
      check("t4_3commas_active", 8'(active), 8'h00);
      send_bits(BC, 8);
      check("t4_active", 8'(active), 8'h01);

      // Reset mid-byte while locked.
      send_bits(8'hA5, 8);
      check("t5_a5_par", paralelo_out, 8'hA5);
      send_bits(8'hF0, 4);
      do_reset();
      check("t5_rst_par", paralelo_out, 8'h00);
      check("t5_rst_valid", 8'(valid_out), 8'h00);
      check("t5_rst_active", 8'(active), 8'h00);
      repeat (3) send_bits(BC, 8);
      check("t5_relock_pre", 8'(active), 8'h00);
      send_bits(BC, 8);
      check("t5_relock", 8'(active), 8'h01);

      // Random data with idle gaps; one data byte equals the comma.
      for (int i = 0; i < 64; i++) begin
         repeat ($urandom_range(0, 2)) send_bits(BC, 8);
         b = (i == 10) ? BC : 8'($urandom_range(0, 255));
         if (b != BC) sent_q.push_back(b);
         send_bits(b, 8);
         if (valid_out) rx_q.push_back(paralelo_out);
      end
      check("t6_count", 8'(rx_q.size()), 8'(sent_q.size()));
      for (int i = 0; i < sent_q.size() && i < rx_q.size(); i++)
         check("t6_byte", rx_q[i], sent_q[i]);

      repeat (2) @(posedge clk8f);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
